spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) initiator: the controller end of the board's SPI link. It drives sclk, cs and mosi toward an SPI slave and captures miso.
- It is used for on-chip loopback against the existing SPI slave, for bench stimulus, and to let the register file push and pull bytes to external SPI peripherals.
- Transfers are 8-bit, MSB first. A start/busy handshake is used, and an optional cs-hold lets several bytes go out as one burst.

Parameters:
- CLK_DIV, 4: clk cycles per sclk half-period. Must be ≥1. Must be ≥4 when the far end is the in-house spi_slave, which uses a 2-FF synchronizer.
- CS_SETUP_CYC, 2: clk cycles cs is low before the first sclk rising edge. Must be ≥1.
- CS_HOLD_CYC, 2: clk cycles cs stays low after the last sclk falling edge. Must be ≥1.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: request a byte transfer. Accepted only when busy=0.
- tx_data, in, 8: byte to send. Sampled on the cycle start is accepted.
- hold_cs, in, 1: keep cs asserted after the current byte. Sampled at byte completion and live in HOLD_WAIT.
- rx_data, out, 8: last received byte.
- rx_valid, out, 1: one-cycle pulse when rx_data updates.
- busy, out, 1: high while a byte is in flight, or in the setup/hold phases.
- sclk, out, 1: SPI clock, idles low.
- cs, out, 1: chip select, active low.
- mosi, out, 1: serial data out.
- miso, in, 1: serial data in.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sclk=0, cs=1, mosi=0, busy=0, rx_valid=0, rx_data=8'h00, divider and bit counters cleared.
  - Reset asserted mid-transfer aborts immediately: cs goes high on reset assertion and no rx_valid is produced.
- States: IDLE, CS_SETUP, TRANSFER, HOLD_WAIT, CS_HOLD. All outputs are registered.
- IDLE: cs=1, busy=0.
  - start=1 → latch tx_data into the tx shift register, mosi=tx_data[7], go to CS_SETUP.
  - On the next cycle cs=0 and busy=1.
- CS_SETUP: holds for CS_SETUP_CYC cycles with sclk=0, then goes to TRANSFER.
- TRANSFER: the divider counts 0..CLK_DIV-1 and sclk toggles when it reaches CLK_DIV-1.
  - Each bit is CLK_DIV cycles low, then CLK_DIV cycles high.
  - miso is sampled into the rx shift register on the clk edge that drives sclk 1→0 (the last cycle of the high half). This is decided, to give slave synchronizer slack.
  - On that same edge mosi advances to the next tx bit, except after bit 0.
  - 8 bits take 16*CLK_DIV cycles.
- Byte completion (8th falling edge):
  - sclk=0, rx_data = full received byte, rx_valid=1 for exactly one cycle.
  - hold_cs=1 → HOLD_WAIT; otherwise → CS_HOLD.
- HOLD_WAIT: cs=0, sclk=0, busy=0.
  - start=1 → load tx_data, mosi=tx_data[7], go to TRANSFER (no setup phase), busy=1.
  - Else hold_cs=0 → CS_HOLD.
  - start has priority when both occur in the same cycle.
- CS_HOLD: cs=0 for CS_HOLD_CYC cycles, then cs=1 and go to IDLE. busy stays 1 throughout.
- Minimum cs-high time is 1 cycle: start is evaluated in IDLE only, and cs rises on entry to IDLE.
- start while busy=1 is ignored; no queueing.
- Single-byte latency: start accept to rx_valid = 1 + CS_SETUP_CYC + 16*CLK_DIV cycles. busy falls CS_HOLD_CYC cycles later.
- mosi holds its last value between bytes. It is don't-care while cs=1.

Test Plan:
- Defaults, single transfer: start with tx_data=8'hA5, hold_cs=0, miso driven from pattern 8'h3C → mosi shifts out 1,0,1,0,0,1,0,1. rx_data=8'h3C with rx_valid pulsed once at cycle 1+2+64 after accept. cs high again 2 cycles later. 8 sclk rising edges counted.
- Burst: bytes 8'h01, 8'h02, 8'h03, with hold_cs=1 on the first two and 0 on the last → cs low continuously across all three bytes, three rx_valid pulses, CS_SETUP occurs only once.
- Loopback via spi_slave at CLK_DIV=4: the slave preloaded with 8'h5A returns 8'h5A while the master sends 8'hC3. The slave's data_received equals 8'hC3.
- Busy-ignore: pulse start with tx_data=8'hFF during TRANSFER → no change to mosi sequence or rx_data, and no extra transaction.
- Reset mid-byte: assert rst_n=0 after 3 sclk edges → cs=1, sclk=0, busy=0 immediately and no rx_valid. A following start with 8'h81 transfers normally.
- Edge parameters: CLK_DIV=1, CS_SETUP_CYC=1, CS_HOLD_CYC=1 → sclk period 2 clk, correct byte 8'h96 in both directions, timing per latency formula.

Source files
------------

// File: rtl/spi_master.sv
// SPI mode-0 initiator: 8-bit MSB-first transfers, start/busy handshake,
// optional cs hold between bytes for multi-byte bursts.
module spi_master #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned CS_SETUP_CYC = 2,
  parameter int unsigned CS_HOLD_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       hold_cs,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    TRANSFER,
    HOLD_WAIT,
    CS_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          busy_q, busy_d;
  logic [7:0]    rx_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    busy_d     = busy_q;
    rx_next    = {rx_sh_q[6:0], miso};

    unique case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        busy_d = 1'b0;
        sclk_d = 1'b0;
        if (start) begin
          tx_d    = tx_data;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = CS_SETUP;
        end
      end

      CS_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = TRANSFER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      TRANSFER: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: capture miso late in the high half
            sclk_d  = 1'b0;
            rx_sh_d = rx_next;
            if (bit_q == 3'd7) begin
              rx_data_d  = rx_next;
              rx_valid_d = 1'b1;
              bit_d      = '0;
              if (hold_cs) begin
                busy_d  = 1'b0;
                state_d = HOLD_WAIT;
              end else begin
                state_d = CS_HOLD;
              end
            end else begin
              bit_d = bit_q + 1'b1;
              tx_d  = {tx_q[6:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD_WAIT: begin
        if (start) begin
          tx_d    = tx_data;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = TRANSFER;
        end else if (!hold_cs) begin
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = CS_HOLD;
        end
      end

      CS_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign sclk     = sclk_q;
  assign cs       = cs_q;
  // tx_q only shifts on non-final bits, so mosi holds its last bit
  assign mosi     = tx_q[7];

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: behavioral mode-0 slaves on two
// instances (default timing and minimum timing parameters).
module tb_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start1 = 0, hold1 = 0, miso1 = 0;
  logic [7:0] tx1 = '0;
  logic [7:0] rxd1;
  logic       rxv1, busy1, sclk1, cs1, mosi1;

  logic       start2 = 0, hold2 = 0, miso2 = 0;
  logic [7:0] tx2 = '0;
  logic [7:0] rxd2;
  logic       rxv2, busy2, sclk2, cs2, mosi2;

  spi_master u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .tx_data(tx1),
    .hold_cs(hold1), .rx_data(rxd1), .rx_valid(rxv1), .busy(busy1),
    .sclk(sclk1), .cs(cs1), .mosi(mosi1), .miso(miso1)
  );

  spi_master #(.CLK_DIV(1), .CS_SETUP_CYC(1), .CS_HOLD_CYC(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .tx_data(tx2),
    .hold_cs(hold2), .rx_data(rxd2), .rx_valid(rxv2), .busy(busy2),
    .sclk(sclk2), .cs(cs2), .mosi(mosi2), .miso(miso2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic extra(input string nm, input logic [7:0] v);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected byte 0x%0h want none", nm, v);
  endtask

  // Scoreboard queues: slave patterns, expected rx bytes, expected mosi bytes
  logic [7:0] pat1[$], exp_rx1[$], exp_tx1[$];
  logic [7:0] pat2[$], exp_rx2[$], exp_tx2[$];

  // Slave model 1
  logic [7:0] ssh1 = '0, srcv1 = '0;
  int pc1 = 0, nc1 = 0, rise1 = 0, csf1 = 0, csr1 = 0, sedge1 = 0;

  always @(negedge cs1) begin
    csf1++;
    pc1 = 0;
    nc1 = 0;
    if (pat1.size() > 0) ssh1 = pat1.pop_front();
    miso1 = ssh1[7];
  end
  always @(posedge cs1) begin
    csr1++;
    pc1 = 0;
    nc1 = 0;
  end
  always @(sclk1) sedge1++;
  always @(posedge sclk1) begin
    rise1++;
    if (cs1 === 1'b0) begin
      srcv1 = {srcv1[6:0], mosi1};
      pc1++;
      if (pc1 == 8) begin
        pc1 = 0;
        if (exp_tx1.size() == 0) extra("mosi1_extra", srcv1);
        else chk("mosi1", srcv1, exp_tx1.pop_front());
      end
    end
  end
  always @(negedge sclk1) begin
    if (cs1 === 1'b0) begin
      nc1++;
      ssh1 = {ssh1[6:0], 1'b0};
      if (nc1 == 8) begin
        nc1 = 0;
        if (pat1.size() > 0) ssh1 = pat1.pop_front();
      end
      miso1 = ssh1[7];
    end
  end

  // Slave model 2
  logic [7:0] ssh2 = '0, srcv2 = '0;
  int pc2 = 0, nc2 = 0, rise2 = 0;
  time t_first2 = 0, t_last2 = 0;

  always @(negedge cs2) begin
    pc2 = 0;
    nc2 = 0;
    if (pat2.size() > 0) ssh2 = pat2.pop_front();
    miso2 = ssh2[7];
  end
  always @(posedge cs2) begin
    pc2 = 0;
    nc2 = 0;
  end
  always @(posedge sclk2) begin
    if (rise2 == 0) t_first2 = $time;
    t_last2 = $time;
    rise2++;
    if (cs2 === 1'b0) begin
      srcv2 = {srcv2[6:0], mosi2};
      pc2++;
      if (pc2 == 8) begin
        pc2 = 0;
        if (exp_tx2.size() == 0) extra("mosi2_extra", srcv2);
        else chk("mosi2", srcv2, exp_tx2.pop_front());
      end
    end
  end
  always @(negedge sclk2) begin
    if (cs2 === 1'b0) begin
      nc2++;
      ssh2 = {ssh2[6:0], 1'b0};
      if (nc2 == 8) begin
        nc2 = 0;
        if (pat2.size() > 0) ssh2 = pat2.pop_front();
      end
      miso2 = ssh2[7];
    end
  end

  // Monitors: pop expected rx byte on every rx_valid pulse
  always @(posedge clk) begin
    #1;
    if (rxv1 === 1'b1) begin
      if (exp_rx1.size() == 0) extra("rx1_extra", rxd1);
      else chk("rx1", rxd1, exp_rx1.pop_front());
    end
    if (rxv2 === 1'b1) begin
      if (exp_rx2.size() == 0) extra("rx2_extra", rxd2);
      else chk("rx2", rxd2, exp_rx2.pop_front());
    end
  end

  task automatic send1(input logic [7:0] d, input logic h);
    @(negedge clk);
    start1 = 1'b1;
    tx1 = d;
    hold1 = h;
    @(posedge clk);
    #1;
    start1 = 1'b0;
  endtask

  task automatic send2(input logic [7:0] d, input logic h);
    @(negedge clk);
    start2 = 1'b1;
    tx2 = d;
    hold2 = h;
    @(posedge clk);
    #1;
    start2 = 1'b0;
  endtask

  // n counts clock edges from the accept edge (inclusive) to rx_valid
  task automatic wait_rx1(output int n);
    n = 1;
    while (rxv1 !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_rx2(output int n);
    n = 1;
    while (rxv2 !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_cs1(output int m);
    m = 0;
    while (cs1 !== 1'b1 && m < 1000) begin
      @(posedge clk);
      #1;
      m++;
    end
  endtask

  task automatic wait_free1(output int m);
    m = 0;
    while (busy1 !== 1'b0 && m < 1000) begin
      @(posedge clk);
      #1;
      m++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", cs1, 1);
    chk("rst_sclk", sclk1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_mosi", mosi1, 0);
    chk("rst_rxv", rxv1, 0);
    chk("rst_rxd", rxd1, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single transfer, defaults
    pat1.push_back(8'h3C);
    exp_rx1.push_back(8'h3C);
    exp_tx1.push_back(8'hA5);
    rise1 = 0;
    send1(8'hA5, 1'b0);
    chk("acc_cs", cs1, 0);
    chk("acc_busy", busy1, 1);
    wait_rx1(n);
    chk("lat_single", n, 67);
    @(posedge clk);
    #1;
    chk("rxv_pulse", rxv1, 0);
    chk("hold_busy", busy1, 1);
    m = 1;
    while (cs1 !== 1'b1 && m < 1000) begin
      @(posedge clk);
      #1;
      m++;
    end
    chk("cs_hold_len", m, 2);
    chk("idle_busy", busy1, 0);
    chk("rises", rise1, 8);

    // Burst of three bytes under one cs
    repeat (3) @(posedge clk);
    csf1 = 0;
    csr1 = 0;
    pat1.push_back(8'h11);
    pat1.push_back(8'h22);
    pat1.push_back(8'h33);
    exp_rx1.push_back(8'h11);
    exp_rx1.push_back(8'h22);
    exp_rx1.push_back(8'h33);
    exp_tx1.push_back(8'h01);
    exp_tx1.push_back(8'h02);
    exp_tx1.push_back(8'h03);
    send1(8'h01, 1'b1);
    wait_free1(m);
    chk("hw_cs", cs1, 0);
    send1(8'h02, 1'b1);
    wait_rx1(n);
    chk("lat_burst", n, 65);
    wait_free1(m);
    send1(8'h03, 1'b0);
    wait_cs1(m);
    chk("burst_csf", csf1, 1);
    chk("burst_csr", csr1, 1);
    chk("burst_done", exp_rx1.size(), 0);

    // start while busy is ignored
    repeat (3) @(posedge clk);
    csf1 = 0;
    pat1.push_back(8'hC3);
    exp_rx1.push_back(8'hC3);
    exp_tx1.push_back(8'h69);
    send1(8'h69, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    start1 = 1'b1;
    tx1 = 8'hFF;
    @(negedge clk);
    start1 = 1'b0;
    wait_cs1(m);
    repeat (60) @(posedge clk);
    #1;
    chk("ign_cs", cs1, 1);
    chk("ign_csf", csf1, 1);
    chk("ign_q", exp_rx1.size(), 0);

    // Reset mid-byte
    pat1.push_back(8'hE7);
    sedge1 = 0;
    send1(8'h18, 1'b0);
    n = 0;
    while (sedge1 < 3 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_edges", sedge1, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_cs", cs1, 1);
    chk("mid_sclk", sclk1, 0);
    chk("mid_busy", busy1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rxd", rxd1, 8'h00);
    repeat (2) @(posedge clk);
    pat1.push_back(8'h7E);
    exp_rx1.push_back(8'h7E);
    exp_tx1.push_back(8'h81);
    send1(8'h81, 1'b0);
    wait_rx1(n);
    chk("lat_after_rst", n, 67);
    wait_cs1(m);

    // Minimum timing parameters
    rise2 = 0;
    pat2.push_back(8'h96);
    exp_rx2.push_back(8'h96);
    exp_tx2.push_back(8'h96);
    send2(8'h96, 1'b0);
    chk("e_acc_cs", cs2, 0);
    wait_rx2(n);
    chk("e_lat", n, 18);
    @(posedge clk);
    #1;
    chk("e_rxv", rxv2, 0);
    chk("e_cs", cs2, 1);
    chk("e_busy", busy2, 0);
    chk("e_rises", rise2, 8);
    chk("e_period", 32'(t_last2 - t_first2), 140);

    repeat (5) @(posedge clk);
    chk("q_rx1", exp_rx1.size(), 0);
    chk("q_tx1", exp_tx1.size(), 0);
    chk("q_rx2", exp_rx2.size(), 0);
    chk("q_tx2", exp_tx2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
